// File: rtl/hub75_rx.sv
// HUB75 receive model: oversamples the panel bus, rebuilds each shifted row and hands it out on valid/ready.
// Optional blank on-time statistics are enabled by defining HUB75_RX_BLANK_STAT_EN.
module hub75_rx #(
  parameter int COLS        = 64,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk_in,
  input  logic                         r0_in,
  input  logic                         r1_in,
  input  logic                         latch_in,
  input  logic                         blank_in,
  input  logic [ADDR_W-1:0]            addr_in,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [COLS-1:0]              row_r0,
  output logic [COLS-1:0]              row_r1,
  output logic [ADDR_W-1:0]            row_addr,
  output logic [$clog2(COLS+2)-1:0]    row_len,
  output logic [15:0]                  on_time,
  output logic                         len_err,
  output logic                         ovf_err
);
  localparam int LEN_W = $clog2(COLS+2);
  localparam int FL_W  = $clog2(SYNC_STAGES+2);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [SYNC_STAGES-1:0]        r_sclk_sync, r_r0_sync, r_r1_sync, r_latch_sync, r_blank_sync;
  logic [SYNC_STAGES*ADDR_W-1:0] r_addr_sync;
  logic                          r_sclk_prev, r_latch_prev;
  logic [FL_W-1:0]               r_flush;
  logic                          r_sclk_rise_p1, r_latch_rise_p1, r_r0_p1, r_r1_p1;
  logic [ADDR_W-1:0]             r_addr_p1;
  logic [COLS-1:0]               r_sr0, r_sr1;
  logic [LEN_W-1:0]              r_cnt;
  logic [0:0]                    r_state;

  logic                          w_sclk_s, w_latch_s, w_blank_s, w_en;
  logic [COLS-1:0]               w_sr0_nxt, w_sr1_nxt;
  logic [LEN_W-1:0]              w_cnt_nxt;
  logic                          w_commit, w_load;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_latch_s = r_latch_sync[SYNC_STAGES-1];
  assign w_blank_s = r_blank_sync[SYNC_STAGES-1];
  // Edges are only trusted once the chains and the previous-value flops hold real samples,
  // so a latch already high when reset releases is not mistaken for a rise.
  assign w_en      = (r_flush == FL_W'(SYNC_STAGES+1));

  // p0: synchronizers and previous-value flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync  <= '0;
      r_r0_sync    <= '0;
      r_r1_sync    <= '0;
      r_latch_sync <= '0;
      r_blank_sync <= '0;
      r_addr_sync  <= '0;
      r_sclk_prev  <= 1'b0;
      r_latch_prev <= 1'b0;
      r_flush      <= '0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_r0_sync    <= {r_r0_sync[SYNC_STAGES-2:0], r0_in};
      r_r1_sync    <= {r_r1_sync[SYNC_STAGES-2:0], r1_in};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch_in};
      r_blank_sync <= {r_blank_sync[SYNC_STAGES-2:0], blank_in};
      r_addr_sync  <= {r_addr_sync[(SYNC_STAGES-1)*ADDR_W-1:0], addr_in};
      r_sclk_prev  <= w_sclk_s;
      r_latch_prev <= w_latch_s;
      if (!w_en) r_flush <= r_flush + 1'b1;
    end
  end

  // p1: edge pulses registered together with the data they qualify
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_rise_p1  <= 1'b0;
      r_latch_rise_p1 <= 1'b0;
      r_r0_p1         <= 1'b0;
      r_r1_p1         <= 1'b0;
      r_addr_p1       <= '0;
    end else begin
      r_sclk_rise_p1  <= w_en & w_sclk_s & ~r_sclk_prev;
      r_latch_rise_p1 <= w_en & w_latch_s & ~r_latch_prev;
      r_r0_p1         <= r_r0_sync[SYNC_STAGES-1];
      r_r1_p1         <= r_r1_sync[SYNC_STAGES-1];
      r_addr_p1       <= r_addr_sync[SYNC_STAGES*ADDR_W-1 -: ADDR_W];
    end
  end

  // Shift-before-commit: the commit sees the post-shift register and count.
  always_comb begin
    w_sr0_nxt = r_sr0;
    w_sr1_nxt = r_sr1;
    w_cnt_nxt = r_cnt;
    if (r_sclk_rise_p1) begin
      w_sr0_nxt = {r_sr0[COLS-2:0], r_r0_p1};
      w_sr1_nxt = {r_sr1[COLS-2:0], r_r1_p1};
      if (r_cnt != LEN_W'(COLS+1)) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign w_commit  = r_latch_rise_p1;
  assign w_load    = w_commit & ((r_state == S_EMPTY) | row_ready);
  assign row_valid = (r_state == S_FULL);

  // p2: shift registers, bit counter, output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr0    <= '0;
      r_sr1    <= '0;
      r_cnt    <= '0;
      r_state  <= S_EMPTY;
      row_r0   <= '0;
      row_r1   <= '0;
      row_addr <= '0;
      row_len  <= '0;
      len_err  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      r_sr0 <= w_sr0_nxt;
      r_sr1 <= w_sr1_nxt;
      r_cnt <= w_commit ? '0 : w_cnt_nxt;
      if (w_load) begin
        row_r0   <= w_sr0_nxt;
        row_r1   <= w_sr1_nxt;
        row_addr <= r_addr_p1;
        row_len  <= w_cnt_nxt;
      end
      if (w_commit && (w_cnt_nxt != LEN_W'(COLS))) len_err <= 1'b1;
      if (w_commit && !w_load) ovf_err <= 1'b1;
      case (r_state)
        S_EMPTY: if (w_commit) r_state <= S_FULL;
        default: if (row_ready && !w_commit) r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef HUB75_RX_BLANK_STAT_EN
  logic [15:0] r_on_cnt, r_on_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on_cnt  <= '0;
      r_on_time <= '0;
    end else begin
      if (w_commit) r_on_cnt <= '0;
      else if (w_en && !w_blank_s && r_on_cnt != 16'hFFFF) r_on_cnt <= r_on_cnt + 1'b1;
      if (w_load) r_on_time <= r_on_cnt;
    end
  end

  assign on_time = r_on_time;
`else
  logic w_unused_blank;
  assign w_unused_blank = w_blank_s;
  assign on_time        = 16'h0000;
`endif
endmodule

// File: doc/hub75_rx.md
# hub75_rx

Receive-side model of the LED panel bus: samples the serial colour/clock/latch/blank lines driven by the panel driver, reassembles each shifted row, and presents it on a valid/ready interface. Sits in the verification and loopback path, on the panel side of the driver, so that driver output can be checked against the intended frame data. Panel inputs are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `COLS`, 64, columns per shifted row (bits per colour line between latches)
- `ADDR_W`, 5, width of the row address bus
- `SYNC_STAGES`, 2, synchronizer depth on every panel input (minimum 2)

Ports:
- `clk` in 1 system clock; must be at least 4x the panel SCLK frequency
- `rst_n` in 1 asynchronous, active-low reset
- `sclk_in` in 1 panel shift clock; data is sampled on its rising edge
- `r0_in` in 1 upper-half red data
- `r1_in` in 1 lower-half red data
- `latch_in` in 1 panel latch; its rising edge commits the row
- `blank_in` in 1 panel blank; high means LEDs off
- `addr_in` in ADDR_W row address, captured at the latch edge
- `row_valid` out 1 captured row available
- `row_ready` in 1 consumer accepts the row
- `row_r0` out COLS upper row; the first bit shifted in is at [COLS-1]
- `row_r1` out COLS lower row; same bit order as `row_r0`
- `row_addr` out ADDR_W address captured with the row
- `row_len` out $clog2(COLS+2) number of SCLK edges seen before the latch
- `on_time` out 16 clk cycles with blank low in the preceding row period
- `len_err` out 1 sticky; set when a latch arrives with `row_len != COLS`
- `ovf_err` out 1 sticky; set when a row is dropped

## Operation
- All five panel inputs and `addr_in` pass through `SYNC_STAGES` flops. One further register holds the previous value of each signal for edge detection.
- On an SCLK rise: shift registers are updated as sr <= {sr[COLS-2:0], bit}. The bit counter increments and saturates at COLS+1.
- On a LATCH rise: a row is committed from the shift registers, the counter value and the address. The counter then clears to 0. The shift registers are not cleared.
- If an SCLK rise and a LATCH rise occur in the same cycle, the shift happens first. The commit includes that bit, and `row_len` counts it.
- Output buffer FSM:
  - EMPTY: a commit loads the outputs and moves to FULL.
  - FULL, `row_ready`=1: with a simultaneous commit, the new row is loaded and the FSM stays FULL; otherwise it moves to EMPTY.
  - FULL, `row_ready`=0: a commit is dropped, `ovf_err` is set, and the outputs are held.
- `len_err` is set when a committed row has `row_len != COLS`. The row is still delivered.
- Output fields are stable while `row_valid` is high and `row_ready` is low.

## Timing
- Reset values: `row_valid`=0, `row_r0`/`row_r1`=0, `row_addr`=0, `row_len`=0, `on_time`=0, `len_err`=0, `ovf_err`=0. Shift registers, counters and synchronizers are all 0. The FSM is EMPTY.
- Reset asserted mid-row or while FULL discards everything at once. No row is emitted after reset deasserts until a full LATCH rise has been seen: a latch already high at deassertion does not count.
- Latency: `row_valid` rises at clk edge SYNC_STAGES+2 after the first edge that samples `latch_in` high.
- SCLK high and low phases must each last at least 2 clk cycles. Data must be stable for SYNC_STAGES+1 clk cycles around the SCLK rise.
- The bus is free-running; there is no backpressure to the panel bus.

## Configuration
- `HUB75_RX_BLANK_STAT_EN` defined:
  - A 16-bit counter increments each clk cycle while synchronized blank is 0, saturating at 65535.
  - At each commit its value is captured with the row into `on_time`, and the counter clears. A cycle where the clear and an increment coincide counts as 0.
- Not defined: the counter is absent and `on_time` is constant 0.

## Test plan
- Shift 64 bits of r0=0xF0F0_0000_0000_0001, r1=~r0, addr=5, then latch, with `row_ready`=1. Expect one `row_valid` pulse with `row_r0`=0xF0F0_0000_0000_0001, `row_r1`=~that, `row_addr`=5, `row_len`=64, and both errors 0.
- Shift 63 bits then latch. Expect the row delivered with `row_len`=63 and `len_err`=1, with `len_err` still 1 after a following good row.
- Hold `row_ready`=0 and send two rows. Expect the first row held, `ovf_err`=1, then the first row's data when `row_ready` is raised.
- Drive SCLK and LATCH rising in the same clk cycle on the 64th bit. Expect `row_len`=64 with that bit at [0].
- With the macro on, hold blank low for 100 clk cycles within a row. Expect `on_time`=100; with the macro off, expect `on_time`=0.
- Assert `rst_n` low after 30 bits, release, then shift 64 bits and latch. Expect `row_len`=64 and no earlier `row_valid`.
